// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight writers EX..WB, drives forwarding, stall, freeze.
// Optional ID-stage branch hazard detection enabled by defining HAZARD_BRANCH_ID_EN.
module hazard_scoreboard #(
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32,
  localparam int SEL_W     = $clog2(FWD_STAGES+1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_wr_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_load_i,
  input  logic              id_branch_i,
  input  logic              mem_busy_i,
  output logic              stall_o,
  output logic              freeze_o,
  output logic [SEL_W-1:0]  fwd_rs_o,
  output logic [SEL_W-1:0]  fwd_rt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [REG_AW-1:0] rd;
  } ent_t;

  ent_t              ent_q [FWD_STAGES+1];
  logic [REG_AW-1:0] rs0_q;
  logic [REG_AW-1:0] rt0_q;
  logic              use_rs0_q;
  logic              use_rt0_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              load_use;
  logic              br_haz;

  // r0 is hardwired, so a writer of r0 never produces a match
  function automatic logic hit(input ent_t e, input logic [REG_AW-1:0] r);
    return e.valid && e.wr && (e.rd == r) && (e.rd != '0);
  endfunction

  function automatic logic id_hit(input ent_t e, input logic urs,
                                  input logic [REG_AW-1:0] rs,
                                  input logic urt,
                                  input logic [REG_AW-1:0] rt);
    return (urs && hit(e, rs)) || (urt && hit(e, rt));
  endfunction

  // descending scan so the youngest match overwrites older ones
  always_comb begin
    fwd_rs_o = '0;
    fwd_rt_o = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (!(ent_q[k].load && k < LOAD_STAGE)) begin
        if (use_rs0_q && hit(ent_q[k], rs0_q))
          fwd_rs_o = SEL_W'(k);
        if (use_rt0_q && hit(ent_q[k], rt0_q))
          fwd_rt_o = SEL_W'(k);
      end
    end
  end

  always_comb begin
    load_use = 1'b0;
    for (int j = 0; j <= FWD_STAGES; j++) begin
      if (ent_q[j].load && (j + 1 < LOAD_STAGE) &&
          id_hit(ent_q[j], id_use_rs_i, id_rs_i,
                 id_use_rt_i, id_rt_i))
        load_use = 1'b1;
    end
    load_use = load_use && id_valid_i;
  end

`ifdef HAZARD_BRANCH_ID_EN
  // WB is excluded: the register file writes through to ID reads
  always_comb begin
    br_haz = 1'b0;
    for (int j = 0; j < FWD_STAGES; j++) begin
      if (id_hit(ent_q[j], id_use_rs_i, id_rs_i,
                 id_use_rt_i, id_rt_i))
        br_haz = 1'b1;
    end
    br_haz = br_haz && id_branch_i && id_valid_i;
  end
`else
  logic unused_branch;
  assign unused_branch = id_branch_i;
  assign br_haz = 1'b0;
`endif

  assign freeze_o    = mem_busy_i & ~rst_i;
  assign stall_o     = (load_use | br_haz) & ~freeze_o;
  assign stall_cnt_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k <= FWD_STAGES; k++)
        ent_q[k] <= '0;
      rs0_q     <= '0;
      rt0_q     <= '0;
      use_rs0_q <= 1'b0;
      use_rt0_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (stall_o && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
      if (!freeze_o) begin
        for (int k = 1; k <= FWD_STAGES; k++)
          ent_q[k] <= ent_q[k-1];
        if (id_valid_i && !stall_o) begin
          ent_q[0]  <= '{valid: 1'b1, wr: id_wr_i,
                         load: id_load_i, rd: id_rd_i};
          rs0_q     <= id_rs_i;
          rt0_q     <= id_rt_i;
          use_rs0_q <= id_use_rs_i;
          use_rt0_q <= id_use_rt_i;
        end else begin
          ent_q[0]  <= '0;
          rs0_q     <= '0;
          rt0_q     <= '0;
          use_rs0_q <= 1'b0;
          use_rt0_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised hazard detection and forwarding controller for the 5-stage MIPS pipeline. Generalised to any number of forwarding stages, a configurable load-result stage, and memory wait-states.
- Tracks every in-flight register writer from EX through WB in a shift-register scoreboard.
- Drives the EX operand forwarding selects, the ID stall (PC and IF/ID hold, bubble into ID/EX), and a global pipeline freeze.
- Keeps a saturating stall-cycle counter.

## Interface
Parameters:
- FWD_STAGES, default 2: post-EX stages able to forward. Legal range 1..6. Entry FWD_STAGES is WB.
- LOAD_STAGE, default 2: first entry index where load data is forwardable. Legal range 1..FWD_STAGES.
- REG_AW, default 5: register address width.
- CNT_W, default 32: stall counter width.

Ports (clock and reset are decided: one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  ID holds a real instruction (0 when flushed)
- id_rs_i, id_rt_i  in  REG_AW  ID source registers
- id_use_rs_i, id_use_rt_i  in  1  ID instruction reads rs / rt
- id_wr_i  in  1  ID instruction writes a register
- id_rd_i  in  REG_AW  ID destination, already RegDst-resolved
- id_load_i  in  1  ID instruction is a load
- id_branch_i  in  1  ID instruction is a branch compared in ID
- mem_busy_i  in  1  data memory not ready
- stall_o  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- freeze_o  out  1  hold every pipeline register
- fwd_rs_o, fwd_rt_o  out  SEL_W  EX operand source; SEL_W = $clog2(FWD_STAGES+1)
- stall_cnt_o  out  CNT_W  stall cycles since reset, saturating

## Operation
Scoreboard contents:
- Entries 0..FWD_STAGES, each holding {valid, wr, rd, load}.
- Entry 0 is the EX instruction and also holds {rs, rt, use_rs, use_rt}.
- An entry with rd==0 never matches a source register.

Advance rules:
- freeze_o=1: all entries hold.
- Otherwise entry k <= entry k-1.
- Entry 0 <= the ID record when stall_o=0 and id_valid_i=1. In every other case entry 0 <= a bubble (valid=0).

Forwarding (combinational from entry 0):
- fwd_rs_o = the smallest k in 1..FWD_STAGES where entry k is valid & wr & rd==rs0 & use_rs0, and not (load & k<LOAD_STAGE).
- If no such k, fwd_rs_o = 0, meaning the register file / ID/EX value.
- fwd_rt_o is derived the same way from rt0.
- Encoding: select k means the result register of stage k.

Load-use stall:
- Asserted when id_valid_i=1, a used ID source matches entry j (valid, wr, load, same rd), and j+1 < LOAD_STAGE.

Freeze and stall outputs:
- freeze_o = mem_busy_i & ~rst_i.
- stall_o = (load-use | branch hazard) & ~freeze_o.

Stall counter:
- stall_cnt_o increments by 1 every cycle stall_o=1.
- It holds at all-ones once saturated.

## Timing
- Reset: all entries invalid, stall_cnt_o=0. Hence stall_o=0, fwd_rs_o=0 and fwd_rt_o=0 in the cycle after the reset edge. Reset wins over a simultaneous mem_busy_i.
- Forwarding selects and stall_o are combinational, with zero latency from the registered scoreboard and the ID inputs.
- A load-use stall lasts LOAD_STAGE-1-j cycles; with defaults, exactly 1 cycle.
- mem_busy_i during a stall: freeze_o=1, stall_o=0, and the counter does not increment. The stall re-evaluates when mem_busy_i drops.
- Multiple matching entries: the youngest one, with the smallest k, wins.
- A flush (id_valid_i=0) forces stall_o=0 in the same cycle.

## Configuration
- HAZARD_BRANCH_ID_EN defined:
  - A branch hazard is asserted when id_branch_i=1, id_valid_i=1, and a used source matches a valid writer in entries 0..FWD_STAGES-1.
  - The WB entry is excluded: the register file write-through covers it.
  - The stall persists until the writer reaches WB. With defaults, an ALU writer in EX stalls 2 cycles.
- HAZARD_BRANCH_ID_EN undefined:
  - id_branch_i is ignored; branch hazard = 0.
  - Branches are resolved in EX through the normal forwarding.

## Test plan
- Back-to-back dependency: ADD r3 then SUB r4,r3,r1 -> fwd_rs_o=1 while SUB is in EX, stall_o=0, stall_cnt_o=0.
- Two-apart dependency: ADD r3, NOP, OR r5,r3,r3 -> fwd_rs_o=2 and fwd_rt_o=2. With ADD r3 in both entries 1 and 2, select = 1.
- Load-use: LW r2 then ADD r6,r2,r2 -> stall_o=1 for exactly 1 cycle, a bubble in entry 0, then fwd_rs_o=2, and stall_cnt_o=1.
- mem_busy_i high 3 cycles during a load-use stall -> freeze_o=1 for 3 cycles, scoreboard unchanged, stall_o=0 in those cycles, 1-cycle stall afterwards.
- HAZARD_BRANCH_ID_EN: ADD r1 then BEQ r1,r0 -> stall_o=1 for 2 cycles. Undefined -> stall_o=0. Writes to r0 never forward or stall.
- Reset asserted mid-stall -> next cycle all outputs 0. Counter saturation is checked with CNT_W=4: 20 stall cycles -> stall_cnt_o=15.
